subtractor_32bit_pipe: RTL and testbench

//   Two-stage pipelined 32-bit subtractor D = A - B with borrow out. It is the inverse-direction

---
 rtl/subtractor_32bit_pipe.sv | 117 +++++++++++
 tb/tb_subtractor_32bit_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/subtractor_32bit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : subtractor_32bit_pipe
// Brief    : Two-stage valid/ready pipelined subtractor D = A - B with borrow
//            out. Optional signed-overflow flag under SUB_OVF_FLAG_EN.
// Revision : 1.0  initial release
// ============================================================================
module subtractor_32bit_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             B32
`ifdef SUB_OVF_FLAG_EN
    ,
    output logic             OVF
`endif
);

    localparam int c_HW = WIDTH / 2;

    logic             r_s1_valid;
    logic [c_HW-1:0]  r_s1_lo;
    logic             r_s1_c;
    logic [c_HW-1:0]  r_s1_a_hi;
    logic [c_HW-1:0]  r_s1_nb_hi;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_d;
    logic             r_b32;

    logic             w_s1_load;
    logic             w_s2_load;
    logic [WIDTH-1:0] w_nb;
    logic [c_HW:0]    w_lo_sum;
    logic [c_HW:0]    w_hi_sum;

    // A - B computed as A + ~B + 1; the +1 enters as the low-half carry-in.
    assign w_nb     = ~B;
    assign w_lo_sum = {1'b0, A[c_HW-1:0]} + {1'b0, w_nb[c_HW-1:0]}
                    + {{c_HW{1'b0}}, 1'b1};
    assign w_hi_sum = {1'b0, r_s1_a_hi} + {1'b0, r_s1_nb_hi}
                    + {{c_HW{1'b0}}, r_s1_c};

    assign w_s2_load = r_s1_valid & (~r_s2_valid | out_ready);
    assign in_ready  = ~r_s1_valid | w_s2_load;
    assign w_s1_load = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_lo    <= '0;
            r_s1_c     <= 1'b0;
            r_s1_a_hi  <= '0;
            r_s1_nb_hi <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= 1'b1;
                r_s1_lo    <= w_lo_sum[c_HW-1:0];
                r_s1_c     <= w_lo_sum[c_HW];
                r_s1_a_hi  <= A[WIDTH-1:c_HW];
                r_s1_nb_hi <= w_nb[WIDTH-1:c_HW];
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Output registers only change on advance, so they hold under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_d        <= '0;
            r_b32      <= 1'b0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_d        <= {w_hi_sum[c_HW-1:0], r_s1_lo};
                r_b32      <= ~w_hi_sum[c_HW];
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign D         = r_d;
    assign B32       = r_b32;

`ifdef SUB_OVF_FLAG_EN
    logic r_ovf;
    logic w_ovf;

    // Operand sign bits are the MSBs already held in the upper-half registers.
    assign w_ovf = (r_s1_a_hi[c_HW-1] ^ ~r_s1_nb_hi[c_HW-1])
                 & (w_hi_sum[c_HW-1] ^ r_s1_a_hi[c_HW-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_s2_load) begin
            r_ovf <= w_ovf;
        end
    end

    assign OVF = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_subtractor_32bit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_subtractor_32bit_pipe
// Brief    : Self-checking bench: directed vector table, backpressure and
//            reset sequences, and a randomized stream against a queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_subtractor_32bit_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] D;
    logic        B32;
`ifdef SUB_OVF_FLAG_EN
    logic        ovf;
`endif

    subtractor_32bit_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .B32       (B32)
`ifdef SUB_OVF_FLAG_EN
        ,
        .OVF       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic        b;
        logic        o;
    } res_t;

    // Reference: plain 33-bit unsigned subtraction plus the signed-overflow rule.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        logic [32:0] full;
        full = {1'b0, a} - {1'b0, b};
        r.d  = full[31:0];
        r.b  = (a < b);
        r.o  = (a[31] != b[31]) && (r.d[31] != a[31]);
        return r;
    endfunction

    res_t        exp_q[$];
    int          n_out = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d;
    logic        prev_b;

    // Inputs change just after posedge, so values at negedge are what the next edge sees.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_d", {32'd0, D}, {32'd0, prev_d});
                chk("hold_b32", {63'd0, B32}, {63'd0, prev_b});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'd1, 64'd0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("stream_d", {32'd0, D}, {32'd0, e.d});
                    chk("stream_b32", {63'd0, B32}, {63'd0, e.b});
`ifdef SUB_OVF_FLAG_EN
                    chk("stream_ovf", {63'd0, ovf}, {63'd0, e.o});
`endif
                end
                n_out++;
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = D;
            prev_b     = B32;
            if (in_valid && in_ready)
                exp_q.push_back(model(A, B));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_op;
        case ($urandom % 7)
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_FFFF;
            3:       return 32'h0001_0000;
            4:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        b32;
        logic        ovf;
    } vec_t;

    vec_t        tbl[10];
    logic [31:0] bp_a[4];
    logic [31:0] bp_b[4];
    int          acc;
    int          cnt;
    int          base_out;
    logic        fire;

    initial begin
        tbl[0] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0};
        tbl[1] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[2] = '{32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0};
        tbl[3] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0};
        tbl[4] = '{32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0};
        tbl[5] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
        tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
        tbl[7] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0};
        tbl[8] = '{32'h0000_0000, 32'h0001_0000, 32'hFFFF_0000, 1'b1, 1'b0};
        tbl[9] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};
        bp_a   = '{32'h0000_0010, 32'h0000_0100, 32'h0000_0000, 32'h8000_0000};
        bp_b   = '{32'h0000_0001, 32'h0000_0200, 32'h0000_0001, 32'h8000_0000};

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_d", {32'd0, D}, 64'd0);
        chk("rst_b32", {63'd0, B32}, 64'd0);
`ifdef SUB_OVF_FLAG_EN
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
`endif
        rst_n = 1'b1;
        tick;

        // Directed vectors, one at a time, checking the two-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("tbl_in_ready", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b1;
            A = tbl[i].a;
            B = tbl[i].b;
            tick;
            in_valid = 1'b0;
            chk("tbl_not_early", {63'd0, out_valid}, 64'd0);
            cnt = 0;
            while (!out_valid && cnt < 8) begin
                tick;
                cnt++;
            end
            chk("tbl_latency", cnt, 64'd1);
            chk("tbl_d", {32'd0, D}, {32'd0, tbl[i].d});
            chk("tbl_b32", {63'd0, B32}, {63'd0, tbl[i].b32});
`ifdef SUB_OVF_FLAG_EN
            chk("tbl_ovf", {63'd0, ovf}, {63'd0, tbl[i].ovf});
`endif
            tick;
        end

        // Backpressure: only two pairs fit while the output is stalled
        base_out  = n_out;
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6 && acc < 4; c++) begin
            in_valid = 1'b1;
            A = bp_a[acc];
            B = bp_b[acc];
            @(negedge clk);
            fire = in_ready;
            tick;
            if (fire) acc++;
        end
        chk("bp_accepted", acc, 64'd2);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_first_d", {32'd0, D}, 64'h0000_000F);
        repeat (3) tick;
        chk("bp_held_d", {32'd0, D}, 64'h0000_000F);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            in_valid = 1'b1;
            A = bp_a[acc];
            B = bp_b[acc];
            @(negedge clk);
            fire = in_ready;
            tick;
            if (fire) acc++;
        end
        in_valid = 1'b0;
        cnt = 0;
        while ((exp_q.size() != 0 || out_valid) && cnt < 20) begin
            tick;
            cnt++;
        end
        chk("bp_all_out", n_out - base_out, 64'd4);

        // Reset mid-operation discards both in-flight pairs
        out_ready = 1'b0;
        in_valid  = 1'b1;
        A = 32'h0000_0009;
        B = 32'h0000_0004;
        tick;
        A = 32'h0000_0007;
        B = 32'h0000_0008;
        tick;
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_d", {32'd0, D}, 64'd0);
        out_ready = 1'b1;
        base_out = n_out;
        repeat (4) tick;
        chk("mid_rst_no_stale", n_out - base_out, 64'd0);

        // Randomized stream with random backpressure
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            A = rand_op();
            B = rand_op();
            tick;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        while ((exp_q.size() != 0 || out_valid) && cnt < 20) begin
            tick;
            cnt++;
        end
        chk("rand_drained", exp_q.size(), 64'd0);
        chk("rand_idle", {63'd0, out_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
